// File: rtl/hazard_scoreboard.sv
// Destination-tag scoreboard for the EXE/MEM/WB stages: drives bypass tags,
// raises decode stalls for hazards the bypass network cannot cover.
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                forward_enb,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_src1,
  input  logic [REG_AW-1:0]   id_src2,
  input  logic                id_two_src,
  input  logic [REG_AW-1:0]   id_dest,
  input  logic                id_wb_en,
  input  logic                id_mem_read,
  input  logic                flush,
  input  logic                sram_ready,
  output logic                hazard_stall,
  output logic                freeze,
  output logic [REG_AW-1:0]   exe_dest,
  output logic                exe_wb_en,
  output logic [REG_AW-1:0]   mem_dest,
  output logic                mem_wb_en,
  output logic [REG_AW-1:0]   wb_dest,
  output logic                wb_wb_en,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic              exe_valid_q, exe_valid_d;
  logic [REG_AW-1:0] exe_dest_q, exe_dest_d;
  logic              exe_wb_en_q, exe_wb_en_d;
  logic              exe_mem_read_q, exe_mem_read_d;
  logic              mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic              mem_wb_en_q, mem_wb_en_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
  logic              wb_wb_en_q, wb_wb_en_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic exe_hit;
  logic mem_hit;
  logic id_bubble;

  function automatic logic src_match(input logic              idv,
                                     input logic              st_valid,
                                     input logic              st_wb_en,
                                     input logic [REG_AW-1:0] st_dest,
                                     input logic [REG_AW-1:0] src);
    return idv & st_valid & st_wb_en & (st_dest == src);
  endfunction

  assign freeze = ~sram_ready;

  always_comb begin
    exe_hit = src_match(id_valid, exe_valid_q, exe_wb_en_q, exe_dest_q, id_src1) |
              (id_two_src & src_match(id_valid, exe_valid_q, exe_wb_en_q, exe_dest_q, id_src2));
    mem_hit = src_match(id_valid, mem_valid_q, mem_wb_en_q, mem_dest_q, id_src1) |
              (id_two_src & src_match(id_valid, mem_valid_q, mem_wb_en_q, mem_dest_q, id_src2));
    // With bypass only a load still in EXE is uncoverable; WB never stalls.
    if (forward_enb) hazard_stall = exe_hit & exe_mem_read_q;
    else             hazard_stall = exe_hit | mem_hit;
    id_bubble = hazard_stall | flush | ~id_valid;
  end

  always_comb begin
    exe_valid_d    = exe_valid_q;
    exe_dest_d     = exe_dest_q;
    exe_wb_en_d    = exe_wb_en_q;
    exe_mem_read_d = exe_mem_read_q;
    mem_valid_d    = mem_valid_q;
    mem_dest_d     = mem_dest_q;
    mem_wb_en_d    = mem_wb_en_q;
    wb_valid_d     = wb_valid_q;
    wb_dest_d      = wb_dest_q;
    wb_wb_en_d     = wb_wb_en_q;
    stall_cnt_d    = stall_cnt_q;
    if (!freeze) begin
      wb_valid_d  = mem_valid_q;
      wb_dest_d   = mem_dest_q;
      wb_wb_en_d  = mem_wb_en_q;
      mem_valid_d = exe_valid_q;
      mem_dest_d  = exe_dest_q;
      mem_wb_en_d = exe_wb_en_q;
      if (id_bubble) begin
        exe_valid_d    = 1'b0;
        exe_dest_d     = '0;
        exe_wb_en_d    = 1'b0;
        exe_mem_read_d = 1'b0;
      end else begin
        exe_valid_d    = 1'b1;
        exe_dest_d     = id_dest;
        exe_wb_en_d    = id_wb_en;
        exe_mem_read_d = id_mem_read;
      end
      if (hazard_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_valid_q    <= 1'b0;
      exe_dest_q     <= '0;
      exe_wb_en_q    <= 1'b0;
      exe_mem_read_q <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= '0;
      mem_wb_en_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_dest_q      <= '0;
      wb_wb_en_q     <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_dest_q     <= exe_dest_d;
      exe_wb_en_q    <= exe_wb_en_d;
      exe_mem_read_q <= exe_mem_read_d;
      mem_valid_q    <= mem_valid_d;
      mem_dest_q     <= mem_dest_d;
      mem_wb_en_q    <= mem_wb_en_d;
      wb_valid_q     <= wb_valid_d;
      wb_dest_q      <= wb_dest_d;
      wb_wb_en_q     <= wb_wb_en_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  always_comb begin
    exe_wb_en = exe_valid_q & exe_wb_en_q;
    mem_wb_en = mem_valid_q & mem_wb_en_q;
    wb_wb_en  = wb_valid_q & wb_wb_en_q;
    exe_dest  = exe_valid_q ? exe_dest_q : '0;
    mem_dest  = mem_valid_q ? mem_dest_q : '0;
    wb_dest   = wb_valid_q ? wb_dest_q : '0;
    busy_mask = '0;
    if (exe_wb_en) busy_mask[exe_dest_q] = 1'b1;
    if (mem_wb_en) busy_mask[mem_dest_q] = 1'b1;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second narrow-counter instance
// exercises stall_cnt saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        forward_enb;
  logic        id_valid;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        id_two_src, id_wb_en, id_mem_read;
  logic        flush, sram_ready;

  logic        hazard_stall, freeze;
  logic [3:0]  exe_dest, mem_dest, wb_dest;
  logic        exe_wb_en, mem_wb_en, wb_wb_en;
  logic [15:0] busy_mask;
  logic [15:0] stall_cnt;

  logic        s_hazard_stall, s_freeze;
  logic [3:0]  s_exe_dest, s_mem_dest, s_wb_dest;
  logic        s_exe_wb_en, s_mem_wb_en, s_wb_wb_en;
  logic [15:0] s_busy_mask;
  logic [1:0]  s_stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .forward_enb(forward_enb), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .flush(flush), .sram_ready(sram_ready),
    .hazard_stall(hazard_stall), .freeze(freeze),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .forward_enb(forward_enb), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .flush(flush), .sram_ready(sram_ready),
    .hazard_stall(s_hazard_stall), .freeze(s_freeze),
    .exe_dest(s_exe_dest), .exe_wb_en(s_exe_wb_en), .mem_dest(s_mem_dest), .mem_wb_en(s_mem_wb_en),
    .wb_dest(s_wb_dest), .wb_wb_en(s_wb_wb_en), .busy_mask(s_busy_mask), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic we, input logic mr);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = we; id_mem_read = mr;
  endtask

  task automatic chk_tags(input string tag, input logic [3:0] e, input logic [3:0] m,
                          input logic [3:0] w);
    chk({tag, "_exe"}, 32'(exe_dest), 32'(e));
    chk({tag, "_mem"}, 32'(mem_dest), 32'(m));
    chk({tag, "_wb"},  32'(wb_dest),  32'(w));
  endtask

  initial begin
    rst_n = 1'b0; forward_enb = 1'b1; flush = 1'b0; sram_ready = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_freeze_hi", 32'(freeze), 32'd1);
    sram_ready = 1'b1;
    #1;
    chk("rst_freeze_lo", 32'(freeze), 32'd0);
    chk("rst_stall", 32'(hazard_stall), 32'd0);
    chk_tags("rst", 4'd0, 4'd0, 4'd0);
    chk("rst_wben", 32'({exe_wb_en, mem_wb_en, wb_wb_en}), 32'd0);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Load-use with forwarding: LDR r3 ; ADD r1,r3,r2
    tick();
    set_id(1, 0, 0, 0, 3, 1, 1);
    #1 chk("lu_ld_nostall", 32'(hazard_stall), 32'd0);
    tick();
    set_id(1, 3, 2, 1, 1, 1, 0);
    #1 chk("lu_stall", 32'(hazard_stall), 32'd1);
    chk("lu_exe", 32'({exe_wb_en, exe_dest}), 32'h13);
    chk("lu_busy", 32'(busy_mask), 32'h0008);
    tick();
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_bubble", 32'({exe_wb_en, exe_dest}), 32'h00);
    chk("lu_mem", 32'({mem_wb_en, mem_dest}), 32'h13);
    chk("lu_release", 32'(hazard_stall), 32'd0);
    tick();
    chk_tags("lu_adv", 4'd1, 4'd0, 4'd3);
    chk("lu_cnt2", 32'(stall_cnt), 32'd1);

    // ALU-ALU with forwarding: ADD r3 ; SUB r4,r3
    set_id(1, 5, 6, 1, 3, 1, 0);
    #1 chk("aa_first", 32'(hazard_stall), 32'd0);
    tick();
    set_id(1, 3, 3, 0, 4, 1, 0);
    #1 chk("aa_nostall", 32'(hazard_stall), 32'd0);
    tick();
    chk("aa_mem", 32'({mem_wb_en, mem_dest}), 32'h13);
    chk("aa_exe", 32'(exe_dest), 32'd4);
    chk("aa_busy", 32'(busy_mask), 32'h0018);
    chk("aa_cnt", 32'(stall_cnt), 32'd1);

    // No forwarding: ADD r3 ; ADD r5,r3,r0 stalls on EXE then MEM
    forward_enb = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk_tags("nf_drain", 4'd0, 4'd0, 4'd0);
    set_id(1, 7, 8, 1, 3, 1, 0);
    #1 chk("nf_first", 32'(hazard_stall), 32'd0);
    tick();
    set_id(1, 3, 0, 1, 5, 1, 0);
    #1 chk("nf_stall_exe", 32'(hazard_stall), 32'd1);
    tick();
    chk("nf_cnt1", 32'(stall_cnt), 32'd2);
    chk("nf_mem", 32'(mem_dest), 32'd3);
    chk("nf_stall_mem", 32'(hazard_stall), 32'd1);
    tick();
    chk("nf_cnt2", 32'(stall_cnt), 32'd3);
    chk("nf_wb", 32'({wb_wb_en, wb_dest}), 32'h13);
    chk("nf_wb_nostall", 32'(hazard_stall), 32'd0);
    chk("sat_cnt3", 32'(s_stall_cnt), 32'd3);
    tick();
    chk("nf_issue", 32'(exe_dest), 32'd5);
    chk("nf_cnt3", 32'(stall_cnt), 32'd3);

    // Unused src2 must not stall on a pending load
    forward_enb = 1'b1;
    set_id(1, 0, 0, 0, 3, 1, 1);
    tick();
    set_id(1, 9, 3, 0, 10, 1, 0);
    #1 chk("two_src0", 32'(hazard_stall), 32'd0);
    id_two_src = 1'b1;
    #1 chk("two_src1", 32'(hazard_stall), 32'd1);
    id_two_src = 1'b0;
    tick();
    chk_tags("pre_frz", 4'd10, 4'd3, 4'd5);

    // Freeze with the load in MEM
    set_id(0, 0, 0, 0, 0, 0, 0);
    sram_ready = 1'b0;
    #1 chk("frz_on", 32'(freeze), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_tags("frz_hold", 4'd10, 4'd3, 4'd5);
      chk("frz_cnt", 32'(stall_cnt), 32'd3);
    end
    sram_ready = 1'b1;
    #1 chk("frz_off", 32'(freeze), 32'd0);
    tick();
    chk_tags("frz_resume", 4'd0, 4'd10, 4'd3);

    // Flush together with a pending load-use stall
    set_id(1, 0, 0, 0, 3, 1, 1);
    tick();
    set_id(1, 3, 0, 0, 1, 1, 0);
    flush = 1'b1;
    #1 chk("fl_stall", 32'(hazard_stall), 32'd1);
    tick();
    chk("fl_bubble", 32'({exe_wb_en, exe_dest}), 32'h00);
    chk("fl_cnt", 32'(stall_cnt), 32'd4);
    chk("sat_hold", 32'(s_stall_cnt), 32'd3);
    flush = 1'b0;
    set_id(1, 0, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 0, 0, 2, 1, 0);
    sram_ready = 1'b0;
    #1 chk("rf_stall", 32'(hazard_stall), 32'd1);
    tick(); tick();
    chk("rf_cnt_hold", 32'(stall_cnt), 32'd4);
    chk("rf_exe_hold", 32'(exe_dest), 32'd7);

    // Reset mid-freeze
    rst_n = 1'b0;
    #1;
    chk_tags("rr", 4'd0, 4'd0, 4'd0);
    chk("rr_wben", 32'({exe_wb_en, mem_wb_en, wb_wb_en}), 32'd0);
    chk("rr_busy", 32'(busy_mask), 32'd0);
    chk("rr_cnt", 32'(stall_cnt), 32'd0);
    chk("rr_stall", 32'(hazard_stall), 32'd0);
    chk("rr_freeze", 32'(freeze), 32'd1);
    rst_n = 1'b1;
    sram_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_tags("post_rst", 4'd0, 4'd0, 4'd0);
    chk("post_rst_busy", 32'(busy_mask), 32'd0);
    chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst_stall", 32'(hazard_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
